// File: rtl/reg_wb_arbiter.sv
// Register-file write-port arbiter. ALU has priority; a load is forced through after STARVE_MAX losses.
// One cycle from accept to rf_wr_en. Optional macro WB_BYPASS_EN adds fwdA_data/fwdB_data.
module reg_wb_arbiter #(
    parameter int PW         = 3,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          alu_valid,
    output logic          alu_ready,
    input  logic [PW-1:0] alu_addr,
    input  logic [7:0]    alu_data,
    input  logic          alu_zero,
    input  logic          alu_ngtv,
    input  logic          alu_scry,

    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [PW-1:0] ld_addr,
    input  logic [7:0]    ld_data,

    output logic          rf_wr_en,
    output logic [PW-1:0] rf_wr_addr,
    output logic [7:0]    rf_dat_in,
    output logic          rf_zero,
    output logic          rf_ngtv,
    output logic          rf_scry,

    input  logic [PW-1:0] rd_addrA,
    input  logic [PW-1:0] rd_addrB,
    output logic          hazA,
    output logic          hazB,

    output logic [3:0]    starve_cnt
`ifdef WB_BYPASS_EN
    ,
    output logic [7:0]    fwdA_data,
    output logic [7:0]    fwdB_data
`endif
);

    localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);

    logic          w_starve_force;
    logic          w_alu_acc;
    logic          w_ld_acc;

    logic          r_wr_en;
    logic [PW-1:0] r_wr_addr;
    logic [7:0]    r_dat;
    logic [2:0]    r_flags;     // {zero, ngtv, scry}
    logic [2:0]    r_shadow;    // last ALU flags, replayed on load writes
    logic [3:0]    r_starve_cnt;

    assign w_starve_force = (r_starve_cnt == LP_STARVE_MAX);

    assign alu_ready = !reset && !(ld_valid && w_starve_force);
    assign ld_ready  = !reset && (!alu_valid || w_starve_force);

    assign w_alu_acc = alu_valid && alu_ready;
    assign w_ld_acc  = ld_valid && ld_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_dat        <= '0;
            r_flags      <= '0;
            r_shadow     <= '0;
            r_starve_cnt <= '0;
        end else begin
            if (w_alu_acc) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= alu_addr;
                r_dat     <= alu_data;
                r_flags   <= {alu_zero, alu_ngtv, alu_scry};
                r_shadow  <= {alu_zero, alu_ngtv, alu_scry};
            end else if (w_ld_acc) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= ld_addr;
                r_dat     <= ld_data;
                r_flags   <= r_shadow;
            end else begin
                r_wr_en   <= 1'b0;
            end

            if (w_ld_acc || !ld_valid) begin
                r_starve_cnt <= '0;
            end else if (w_alu_acc && (r_starve_cnt != LP_STARVE_MAX)) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end
    end

    // Gated by reset so a write staged just before reset never reaches the
    // register file while its reset clear is in progress.
    assign rf_wr_en   = r_wr_en && !reset;
    assign rf_wr_addr = r_wr_addr;
    assign rf_dat_in  = r_dat;
    assign rf_zero    = r_flags[2];
    assign rf_ngtv    = r_flags[1];
    assign rf_scry    = r_flags[0];
    assign starve_cnt = r_starve_cnt;

    assign hazA = rf_wr_en && (rd_addrA == rf_wr_addr);
    assign hazB = rf_wr_en && (rd_addrB == rf_wr_addr);

`ifdef WB_BYPASS_EN
    assign fwdA_data = hazA ? rf_dat_in : 8'h00;
    assign fwdB_data = hazB ? rf_dat_in : 8'h00;
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Randomized and directed bench for reg_wb_arbiter against a transaction-level model.
module tb_reg_wb_arbiter;
    localparam int PW   = 3;
    localparam int SMAX = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          alu_valid, alu_ready;
    logic [PW-1:0] alu_addr;
    logic [7:0]    alu_data;
    logic          alu_zero, alu_ngtv, alu_scry;
    logic          ld_valid, ld_ready;
    logic [PW-1:0] ld_addr;
    logic [7:0]    ld_data;
    logic          rf_wr_en;
    logic [PW-1:0] rf_wr_addr;
    logic [7:0]    rf_dat_in;
    logic          rf_zero, rf_ngtv, rf_scry;
    logic [PW-1:0] rd_addrA, rd_addrB;
    logic          hazA, hazB;
    logic [3:0]    starve_cnt;
`ifdef WB_BYPASS_EN
    logic [7:0]    fwdA_data, fwdB_data;
`endif

    reg_wb_arbiter #(.PW(PW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .alu_zero(alu_zero), .alu_ngtv(alu_ngtv), .alu_scry(alu_scry),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_dat_in(rf_dat_in),
        .rf_zero(rf_zero), .rf_ngtv(rf_ngtv), .rf_scry(rf_scry),
        .rd_addrA(rd_addrA), .rd_addrB(rd_addrB), .hazA(hazA), .hazB(hazB),
        .starve_cnt(starve_cnt)
`ifdef WB_BYPASS_EN
        , .fwdA_data(fwdA_data), .fwdB_data(fwdB_data)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected write-port state: the write issued by the last grant, if any.
    logic          m_wr_en;
    logic [PW-1:0] m_addr;
    logic [7:0]    m_data;
    logic [2:0]    m_flags;
    logic [2:0]    m_shadow;
    int            m_starve;
    logic          g_a_win, g_l_win;
    logic          s_alu_rdy, s_ld_rdy;

    task automatic step();
        logic frc;
        #1;
        frc     = (m_starve == SMAX);
        g_a_win = !reset && alu_valid && !(ld_valid && frc);
        g_l_win = !reset && ld_valid && (!alu_valid || frc);
        s_alu_rdy = alu_ready;
        s_ld_rdy  = ld_ready;
        chk("alu_ready", 32'(alu_ready), 32'(!reset && !(ld_valid && frc)));
        chk("ld_ready", 32'(ld_ready), 32'(!reset && (!alu_valid || frc)));
        chk("one_grant", 32'(alu_valid && ld_valid && alu_ready && ld_ready), 32'(0));
        chk("wr_en_mid", 32'(rf_wr_en), 32'(m_wr_en && !reset));
        @(posedge clk);
        if (reset) begin
            m_wr_en = 0; m_addr = 0; m_data = 0; m_flags = 0; m_shadow = 0; m_starve = 0;
        end else begin
            if (g_a_win) begin
                m_wr_en = 1; m_addr = alu_addr; m_data = alu_data;
                m_flags = {alu_zero, alu_ngtv, alu_scry};
                m_shadow = m_flags;
            end else if (g_l_win) begin
                m_wr_en = 1; m_addr = ld_addr; m_data = ld_data; m_flags = m_shadow;
            end else begin
                m_wr_en = 0;
            end
            if (g_l_win || !ld_valid) m_starve = 0;
            else if (g_a_win) m_starve = (m_starve + 1 > SMAX) ? SMAX : m_starve + 1;
        end
        #1;
        chk("rf_wr_en", 32'(rf_wr_en), 32'(m_wr_en && !reset));
        chk("rf_wr_addr", 32'(rf_wr_addr), 32'(m_addr));
        chk("rf_dat_in", 32'(rf_dat_in), 32'(m_data));
        chk("rf_flags", 32'({rf_zero, rf_ngtv, rf_scry}), 32'(m_flags));
        chk("starve_cnt", 32'(starve_cnt), 32'(m_starve));
        chk("hazA", 32'(hazA), 32'(m_wr_en && !reset && rd_addrA == m_addr));
        chk("hazB", 32'(hazB), 32'(m_wr_en && !reset && rd_addrB == m_addr));
`ifdef WB_BYPASS_EN
        chk("fwdA", 32'(fwdA_data), 32'((m_wr_en && !reset && rd_addrA == m_addr) ? m_data : 8'h00));
        chk("fwdB", 32'(fwdB_data), 32'((m_wr_en && !reset && rd_addrB == m_addr) ? m_data : 8'h00));
`endif
    endtask

    task automatic set_alu(input logic v, input int a, input int d, input logic [2:0] f);
        alu_valid = v; alu_addr = PW'(a); alu_data = 8'(d);
        {alu_zero, alu_ngtv, alu_scry} = f;
    endtask

    task automatic set_ld(input logic v, input int a, input int d);
        ld_valid = v; ld_addr = PW'(a); ld_data = 8'(d);
    endtask

    initial begin
        m_wr_en = 0; m_addr = 0; m_data = 0; m_flags = 0; m_shadow = 0; m_starve = 0;
        reset = 1;
        set_alu(0, 0, 0, 3'b000);
        set_ld(0, 0, 0);
        rd_addrA = 0; rd_addrB = 1;
        step(); step();
        chk("rst_wr_en", 32'(rf_wr_en), 32'(0));
        chk("rst_starve", 32'(starve_cnt), 32'(0));

        // ALU-only write
        @(negedge clk); reset = 0; set_alu(1, 3, 8'h5A, 3'b101); step();
        chk("alu1_rdy", 32'(s_alu_rdy), 32'(1));
        chk("alu1_wr_en", 32'(rf_wr_en), 32'(1));
        chk("alu1_addr", 32'(rf_wr_addr), 32'(3));
        chk("alu1_data", 32'(rf_dat_in), 32'(8'h5A));
        chk("alu1_flags", 32'({rf_zero, rf_ngtv, rf_scry}), 32'(3'b101));
        @(negedge clk); set_alu(0, 0, 0, 3'b000); step();
        chk("alu1_idle", 32'(rf_wr_en), 32'(0));

        // Load inherits flags from the preceding ALU write
        @(negedge clk); set_alu(1, 1, 8'h11, 3'b011); step();
        @(negedge clk); set_alu(0, 0, 0, 3'b000); set_ld(1, 5, 8'hC3); step();
        chk("ld_flags", 32'({rf_zero, rf_ngtv, rf_scry}), 32'(3'b011));
        chk("ld_data", 32'(rf_dat_in), 32'(8'hC3));
        chk("ld_addr", 32'(rf_wr_addr), 32'(5));
        @(negedge clk); set_ld(0, 0, 0); step();

        // Contention: ALU wins SMAX times, then the load is forced
        for (int k = 1; k <= SMAX; k++) begin
            @(negedge clk); set_alu(1, k, 8'h20 + k, 3'b000); set_ld(1, 6, 8'h99); step();
            chk("cont_alu_rdy", 32'(s_alu_rdy), 32'(1));
            chk("cont_starve", 32'(starve_cnt), 32'(k));
        end
        @(negedge clk); set_alu(1, 7, 8'h44, 3'b000); step();
        chk("force_ld_rdy", 32'(s_ld_rdy), 32'(1));
        chk("force_alu_rdy", 32'(s_alu_rdy), 32'(0));
        chk("force_addr", 32'(rf_wr_addr), 32'(6));
        chk("force_data", 32'(rf_dat_in), 32'(8'h99));
        chk("force_starve", 32'(starve_cnt), 32'(0));
        @(negedge clk); set_ld(0, 0, 0); step();
        chk("after_alu_rdy", 32'(s_alu_rdy), 32'(1));
        chk("after_addr", 32'(rf_wr_addr), 32'(7));

        // Hazard on an in-flight write to reg 2
        @(negedge clk); set_alu(1, 2, 8'h77, 3'b111); rd_addrA = 2; rd_addrB = 4; step();
        chk("hazA_hit", 32'(hazA), 32'(1));
        chk("hazB_miss", 32'(hazB), 32'(0));
`ifdef WB_BYPASS_EN
        chk("fwdA_hit", 32'(fwdA_data), 32'(8'h77));
`endif

        // Reset right after an accepted write
        @(negedge clk); set_alu(1, 3, 8'h55, 3'b111); step();
        @(negedge clk); reset = 1; set_ld(1, 2, 8'h66); step();
        chk("mrst_alu_rdy", 32'(s_alu_rdy), 32'(0));
        chk("mrst_ld_rdy", 32'(s_ld_rdy), 32'(0));
        chk("mrst_wr_en", 32'(rf_wr_en), 32'(0));
        @(negedge clk); step();
        chk("mrst_starve", 32'(starve_cnt), 32'(0));
        @(negedge clk); reset = 0; set_alu(0, 0, 0, 3'b000); set_ld(1, 4, 8'h3C); step();
        chk("mrst_shadow", 32'({rf_zero, rf_ngtv, rf_scry}), 32'(3'b000));

        // Load-only stream
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); set_ld(1, k + 1, 8'hA0 + k); step();
            chk("ldstr_wr_en", 32'(rf_wr_en), 32'(1));
            chk("ldstr_addr", 32'(rf_wr_addr), 32'(k + 1));
            chk("ldstr_starve", 32'(starve_cnt), 32'(0));
        end

        // Random traffic; requesters hold their request until accepted
        @(negedge clk); set_ld(0, 0, 0); step();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 99) < 3);
            if (!alu_valid || g_a_win)
                set_alu(($urandom_range(0, 99) < 70), int'($urandom), int'($urandom), 3'($urandom));
            if (!ld_valid || g_l_win)
                set_ld(($urandom_range(0, 99) < 60), int'($urandom), int'($urandom));
            rd_addrA = PW'($urandom);
            rd_addrB = PW'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: ALU results, which carry flags, and load returns, which carry data only.
- Uses a valid/ready handshake, fixed ALU priority and a starvation guard for loads.
- Output is a registered writeback stage that drives the register file's wr_en, wr_addr, dat_in and flag inputs.
- Provides read-after-write hazard flags for the two register-file read addresses.

Parameters:
- PW, 3: register address width; 2**PW registers.
- STARVE_MAX, 3: consecutive contested cycles a load may lose before it is forced to win; legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU writeback request
- alu_ready  out  1  ALU request accepted this cycle
- alu_addr  in  PW  ALU destination register
- alu_data  in  8  ALU result
- alu_zero, alu_ngtv, alu_scry  in  1 each  ALU flags
- ld_valid  in  1  load writeback request
- ld_ready  out  1  load request accepted this cycle
- ld_addr  in  PW  load destination register
- ld_data  in  8  load data
- rf_wr_en  out  1  register file write enable
- rf_wr_addr  out  PW  register file write address
- rf_dat_in  out  8  register file write data
- rf_zero, rf_ngtv, rf_scry  out  1 each  flag values written with rf_wr_en
- rd_addrA, rd_addrB  in  PW  current register file read addresses
- hazA, hazB  out  1 each  read address matches the write in flight
- starve_cnt  out  4  current load-loss count, for debug

Behaviour:
- Clock and reset: clk, rising edge; reset is synchronous and active-high. Nothing else is sequential.
- Outputs while reset is high:
  - alu_ready=0, ld_ready=0 (combinational gating).
  - After the reset edge: rf_wr_en=0, rf_wr_addr=0, rf_dat_in=0, rf_* flags=0, starve_cnt=0, flag shadow=000.
  - rf_wr_en must stay 0 for the whole reset so the register file's reset clear is not masked by a write.
- starve_force = (starve_cnt == STARVE_MAX).
- Ready logic (combinational):
  - alu_ready = !reset && !(ld_valid && starve_force)
  - ld_ready = !reset && (!alu_valid || starve_force)
  - At most one grant per cycle; never both readies high while both valids are high.
- Grant: acceptance = valid && ready at a rising edge. The accepted request is captured into the stage registers, and the next cycle drives rf_wr_en=1 with the captured addr and data. Latency is one cycle from accept to rf_wr_en; the register file commits on the following edge.
- No accept: rf_wr_en=0 next cycle. Stage addr and data hold their last value.
- ALU grant:
  - rf flags = alu flags.
  - The flag shadow updates to the alu flags.
- Load grant:
  - rf flags = flag shadow, so flags are preserved because the register file writes flags on every wr_en.
  - The shadow is unchanged.
- starve_cnt, per edge:
  - Increments (saturating at STARVE_MAX) when ld_valid && alu_valid && ALU granted.
  - Clears to 0 when the load is granted or ld_valid=0.
  - Otherwise holds.
- Hazards:
  - hazA = rf_wr_en && (rd_addrA == rf_wr_addr); hazB likewise.
  - Combinational; 0 when rf_wr_en=0. Register 0 is not special.
- Both requesters target the same address in consecutive grants: both writes are issued in grant order. No merging.
- Reset mid-operation: the staged write is discarded, so rf_wr_en=0 after the edge. Requests pending at reset are not accepted and must be re-presented by the requester.
- Requesters must hold valid, addr and data stable until ready. The arbiter does not check this.

Optional Feature:
- WB_BYPASS_EN: when defined, adds outputs fwdA_data and fwdB_data (8 bits each).
  - fwdX_data = hazX ? rf_dat_in : 8'h00.
  - Lets the datapath forward the in-flight write without stalling.
- Without the macro, these ports do not exist and consumers must stall on hazA/hazB.

Test Plan:
- Reset, then ALU-only write: alu_valid=1, addr=3, data=8'h5A, flags 1/0/1 for one cycle.
  - Expect alu_ready=1.
  - Next cycle: rf_wr_en=1, rf_wr_addr=3, rf_dat_in=8'h5A, flags 101.
  - Following cycle: rf_wr_en=0.
- Load after an ALU flag write: ALU grant with flags 011, then ld_valid, addr=5, data=8'hC3.
  - The load write carries flags 011, not 000.
- Contention: both valid continuously, STARVE_MAX=3.
  - ALU wins 3 cycles (starve_cnt 1,2,3).
  - 4th cycle: ld_ready=1, alu_ready=0; the load is written.
  - starve_cnt returns to 0 and the ALU wins again.
- Hazard: a write to reg 2 is in flight, rd_addrA=2, rd_addrB=4.
  - hazA=1, hazB=0.
  - With WB_BYPASS_EN: fwdA_data equals the write data.
- Reset mid-operation: accept an ALU write, assert reset on the next edge.
  - rf_wr_en=0 throughout reset; both readies stay 0.
  - starve_cnt=0; the shadow is 000 after release.
- Load-only stream: ld_valid=1 for 4 cycles, alu_valid=0.
  - 4 consecutive writes, one per cycle.
  - starve_cnt stays 0.
